// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order word requests to imem,
// and buffers tagged responses in a small FIFO that drains into the core.
module instruction_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] count_next;
    logic [CW:0]   in_use;

    logic [31:0]   tag_mem [DEPTH];
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic req_fire;
    logic resp_fire;
    logic push;
    logic pop;

    // In-flight requests and buffered words share one credit pool,
    // so a response always finds a free FIFO slot.
    assign in_use = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid = !reset && !redirect_valid && (in_use < LIMIT);
    assign imem_req_addr = fetch_pc;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && (outstanding != '0);
    assign push = resp_fire && (discard == '0) && !redirect_valid;

    assign inst_valid  = (count != '0);
    assign pop         = inst_valid && inst_ready;
    assign instruction = data_mem[rd_ptr];
    assign inst_pc     = pc_mem[rd_ptr];

    always_comb begin
        outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);
        discard_next     = discard;
        count_next       = count + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            discard_next = outstanding_next;
            count_next   = '0;
        end else if (resp_fire && (discard != '0)) begin
            discard_next = discard - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i]  <= '0;
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            discard     <= discard_next;
            count       <= count_next;

            if (redirect_valid)
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (req_fire)
                fetch_pc <= fetch_pc + 32'd4;

            // Tags stay queued across a redirect; stale ones are
            // retired by the discard count as their responses return.
            if (req_fire) begin
                tag_mem[tag_wr] <= fetch_pc;
                tag_wr          <= tag_wr + AW'(1);
            end
            if (resp_fire)
                tag_rd <= tag_rd + AW'(1);

            if (push) begin
                pc_mem[wr_ptr]   <= tag_mem[tag_rd];
                data_mem[wr_ptr] <= imem_resp_data;
            end

            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: vector table, directed corner cases,
// and random traffic checked against a queue-based reference model.
module tb_instruction_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .instruction(instruction),
        .inst_pc(inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    bit rand_rdy = 1'b0;

    // Reference model: requests in flight (with a stale mark set by a
    // redirect), the buffered words, and the next fetch address.
    typedef struct {logic [31:0] pc; bit stale;} fl_t;
    fl_t         inflight[$];
    logic [31:0] buffer[$];
    logic [31:0] delivered[$];
    logic [31:0] mpc;
    bit          model_ok = 1'b0;

    typedef struct {logic [31:0] addr; int due;} mr_t;
    mr_t mq[$];
    int  last_due = 0;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_instr;

    typedef struct {
        bit rst; bit rdy; bit rv; logic [31:0] addr;
        bit iv; logic [31:0] pc; bit z;
    } vec_t;
    vec_t vt[24];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy,
                        input logic rv_in, input logic [31:0] rpc);
        bit          exp_rv, exp_iv, resp_now;
        logic [31:0] raddr;
        fl_t         e;
        int          due;
        @(negedge clk);
        reset          = r;
        inst_ready     = rdy;
        redirect_valid = rv_in;
        redirect_pc    = rpc;
        imem_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        resp_now = 1'b0;
        raddr    = '0;
        if (r) begin
            mq.delete();
            last_due = 0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp_now = 1'b1;
            raddr    = mq[0].addr;
            void'(mq.pop_front());
        end
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? (raddr ^ KEY) : $urandom();
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_iv = inst_valid; s_pc = inst_pc; s_instr = instruction;
        exp_rv = !r && !rv_in && ((inflight.size() + buffer.size()) < DEPTH);
        exp_iv = buffer.size() > 0;
        if (model_ok) begin
            check("req_valid", 32'(s_rv), 32'(exp_rv));
            check("req_addr", s_addr, mpc);
            check("inst_valid", 32'(s_iv), 32'(exp_iv));
            if (exp_iv) begin
                check("inst_pc", s_pc, buffer[0]);
                check("instruction", s_instr, buffer[0] ^ KEY);
            end
        end
        if (!r && imem_req_valid && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{imem_req_addr, due});
        end
        if (r) begin
            inflight.delete();
            buffer.delete();
            mpc      = RPC;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (exp_iv && rdy) begin
                delivered.push_back(buffer[0]);
                void'(buffer.pop_front());
            end
            if (resp_now && inflight.size() > 0) begin
                e = inflight.pop_front();
                if (!e.stale && !rv_in) buffer.push_back(e.pc);
            end
            if (exp_rv && imem_req_ready) begin
                inflight.push_back('{mpc, 1'b0});
                mpc = mpc + 32'd4;
            end
            if (rv_in) begin
                buffer.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                mpc = rpc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n, input logic rdy);
        repeat (n) step(1'b0, rdy, 1'b0, 32'h0);
    endtask

    task automatic set_row(input int i, input bit rst, input bit rdy,
                           input bit rv, input logic [31:0] addr,
                           input bit iv, input logic [31:0] pc, input bit z);
        vt[i] = '{rst, rdy, rv, addr, iv, pc, z};
    endtask

    initial begin
        int bad;
        bit r, rv, rd;
        // Reset, 1-cycle stream, mid-stream reset, then 10 stalled cycles.
        set_row(0, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1);
        set_row(1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        set_row(2, 1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
        set_row(3, 1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0);
        set_row(4, 1'b0, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 1'b0);
        set_row(5, 1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108, 1'b0);
        set_row(6, 1'b1, 1'b1, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b0);
        set_row(7, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1);
        set_row(8, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        set_row(9, 1'b0, 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
        set_row(10, 1'b0, 1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b0);
        set_row(11, 1'b0, 1'b0, 1'b1, 32'h10C, 1'b1, 32'h100, 1'b0);
        for (int i = 12; i < 18; i++)
            set_row(i, 1'b0, 1'b0, 1'b0, 32'h110, 1'b1, 32'h100, 1'b0);
        set_row(18, 1'b0, 1'b1, 1'b0, 32'h110, 1'b1, 32'h100, 1'b0);
        set_row(19, 1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h104, 1'b0);
        set_row(20, 1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h108, 1'b0);
        set_row(21, 1'b0, 1'b1, 1'b1, 32'h118, 1'b1, 32'h10C, 1'b0);
        set_row(22, 1'b0, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h110, 1'b0);
        set_row(23, 1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 32'h114, 1'b0);

        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 24; i++) begin
            step(vt[i].rst, vt[i].rdy, 1'b0, 32'h0);
            check("tbl_req_valid", 32'(s_rv), 32'(vt[i].rv));
            check("tbl_req_addr", s_addr, vt[i].addr);
            check("tbl_inst_valid", 32'(s_iv), 32'(vt[i].iv));
            if (vt[i].iv) begin
                check("tbl_inst_pc", s_pc, vt[i].pc);
                check("tbl_instruction", s_instr, vt[i].pc ^ KEY);
            end
            if (vt[i].z) begin
                check("tbl_reset_pc", s_pc, 32'h0);
                check("tbl_reset_instr", s_instr, 32'h0);
            end
        end

        // Redirect with three requests in flight on a 3-cycle memory.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        lat_lo = 3; lat_hi = 3;
        run(3, 1'b1);
        delivered.delete();
        step(1'b0, 1'b1, 1'b1, 32'h2003);
        run(14, 1'b1);
        check("redir_count_ok", 32'(delivered.size() >= 2), 32'h1);
        if (delivered.size() >= 2) begin
            check("redir_first", delivered[0], 32'h2000);
            check("redir_second", delivered[1], 32'h2004);
        end
        bad = 0;
        foreach (delivered[i]) if (delivered[i] < 32'h2000) bad++;
        check("redir_no_stale", 32'(bad), 32'h0);

        // Redirect coinciding with a pop and an arriving response.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        lat_lo = 1; lat_hi = 1;
        run(4, 1'b1);
        delivered.delete();
        step(1'b0, 1'b1, 1'b1, 32'h3000);
        run(8, 1'b1);
        check("simul_count_ok", 32'(delivered.size() >= 3), 32'h1);
        if (delivered.size() >= 3) begin
            check("simul_popped", delivered[0], 32'h108);
            check("simul_target", delivered[1], 32'h3000);
            check("simul_next", delivered[2], 32'h3004);
        end

        // Address wrap-around after a redirect near the top.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        lat_lo = 2; lat_hi = 2;
        run(3, 1'b1);
        delivered.delete();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run(12, 1'b1);
        check("wrap_count_ok", 32'(delivered.size() >= 3), 32'h1);
        if (delivered.size() >= 3) begin
            check("wrap_0", delivered[0], 32'hFFFF_FFF8);
            check("wrap_1", delivered[1], 32'hFFFF_FFFC);
            check("wrap_2", delivered[2], 32'h0000_0000);
        end

        // One-cycle reset with two requests in flight and two buffered.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        lat_lo = 3; lat_hi = 3;
        run(5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mreset_inst_valid", 32'(s_iv), 32'h0);
        check("mreset_inst_pc", s_pc, 32'h0);
        check("mreset_instr", s_instr, 32'h0);
        check("mreset_req_valid", 32'(s_rv), 32'h1);
        check("mreset_req_addr", s_addr, RPC);

        // Random traffic against the reference model.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        rand_rdy = 1'b1;
        lat_lo = 1; lat_hi = 5;
        delivered.delete();
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            rv = !r && ($urandom_range(0, 19) == 0);
            rd = ($urandom_range(0, 3) != 0);
            step(r, rd, rv, $urandom());
        end
        check("rand_progress", 32'(delivered.size() > 100), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
